// File: rtl/elastic_pipe_buffer_pkg.sv
// ============================================================================
// Module  : elastic_pipe_buffer_pkg
// Brief   : Shared defaults and sizing helpers for the elastic pipeline buffer.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

package elastic_pipe_buffer_pkg;

    localparam int c_default_width = 16;
    localparam int c_default_depth = 1;
    localparam int c_max_depth     = 8;

    // Each stage holds a main and a skid beat, so the count spans 0..2*depth.
    function automatic int epb_count_width(input int depth);
        return $clog2(2 * depth + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/elastic_pipe_buffer_if.sv
// ============================================================================
// Module  : elastic_pipe_buffer_if
// Brief   : Valid/ready payload stream between two pipeline stages.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

interface elastic_pipe_buffer_if
    import elastic_pipe_buffer_pkg::*;
#(
    parameter int WIDTH = c_default_width
) ();

    logic [WIDTH-1:0] data;
    logic             valid;
    logic             ready;

    modport master (
        output data,
        output valid,
        input  ready
    );

    modport slave (
        input  data,
        input  valid,
        output ready
    );

endinterface

`default_nettype wire

// File: rtl/elastic_pipe_buffer_skid_stage.sv
// ============================================================================
// Module  : elastic_pipe_buffer_skid_stage
// Brief   : One register stage with main + skid storage and registered ready.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module elastic_pipe_buffer_skid_stage
    import elastic_pipe_buffer_pkg::*;
#(
    parameter int               WIDTH       = c_default_width,
    parameter logic [WIDTH-1:0] FLUSH_VALUE = '0
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             stall,
    input  wire logic             flush,
    input  wire logic             up_valid,
    input  wire logic [WIDTH-1:0] up_data,
    output logic                  up_ready,
    output logic                  down_valid,
    output logic [WIDTH-1:0]      down_data,
    input  wire logic             down_ready,
    output logic [1:0]            held
);

    logic             r_main_valid;
    logic [WIDTH-1:0] r_main_data;
    logic             r_skid_valid;
    logic [WIDTH-1:0] r_skid_data;

    logic             w_take_in;
    logic             w_take_out;

    // Ready depends only on the skid flag, so no combinational ready chain forms.
    assign up_ready   = ~r_skid_valid;
    assign w_take_in  = up_valid & ~r_skid_valid & ~stall;
    assign w_take_out = r_main_valid & down_ready & ~stall;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_main_valid <= 1'b0;
            r_main_data  <= FLUSH_VALUE;
            r_skid_valid <= 1'b0;
            r_skid_data  <= FLUSH_VALUE;
        end else if (flush) begin
            r_main_valid <= 1'b0;
            r_main_data  <= FLUSH_VALUE;
            r_skid_valid <= 1'b0;
            r_skid_data  <= FLUSH_VALUE;
        end else if (w_take_out) begin
            if (r_skid_valid) begin
                r_main_data  <= r_skid_data;
                r_skid_valid <= 1'b0;
            end else if (w_take_in) begin
                r_main_data  <= up_data;
            end else begin
                r_main_valid <= 1'b0;
            end
        end else if (w_take_in) begin
            // Main busy and not draining: park the newcomer behind it.
            if (r_main_valid) begin
                r_skid_valid <= 1'b1;
                r_skid_data  <= up_data;
            end else begin
                r_main_valid <= 1'b1;
                r_main_data  <= up_data;
            end
        end
    end

    assign down_valid = r_main_valid;
    assign down_data  = r_main_data;
    assign held       = {1'b0, r_main_valid} + {1'b0, r_skid_valid};

endmodule

`default_nettype wire

// File: rtl/elastic_pipe_buffer.sv
// ============================================================================
// Module  : elastic_pipe_buffer
// Brief   : Elastic inter-stage pipeline register with stall, flush and count.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module elastic_pipe_buffer
    import elastic_pipe_buffer_pkg::*;
#(
    parameter int               WIDTH       = c_default_width,
    parameter int               DEPTH       = c_default_depth,
    parameter logic [WIDTH-1:0] FLUSH_VALUE = '0
) (
    input  wire logic                         clk,
    input  wire logic                         rst,
    elastic_pipe_buffer_if.slave              upstream,
    elastic_pipe_buffer_if.master             downstream,
    input  wire logic                         stall,
    input  wire logic                         flush,
    output logic [epb_count_width(DEPTH)-1:0] count
);

    localparam int COUNT_W = epb_count_width(DEPTH);

    logic             w_valid [DEPTH+1];
    logic [WIDTH-1:0] w_data  [DEPTH+1];
    logic             w_ready [DEPTH+1];
    logic [1:0]       w_held  [DEPTH];
    logic [COUNT_W-1:0] w_count;

    assign w_valid[0]     = upstream.valid;
    assign w_data[0]      = upstream.data;
    assign w_ready[DEPTH] = downstream.ready;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
            elastic_pipe_buffer_skid_stage #(
                .WIDTH       (WIDTH),
                .FLUSH_VALUE (FLUSH_VALUE)
            ) u_stage (
                .clk        (clk),
                .rst        (rst),
                .stall      (stall),
                .flush      (flush),
                .up_valid   (w_valid[gi]),
                .up_data    (w_data[gi]),
                .up_ready   (w_ready[gi]),
                .down_valid (w_valid[gi+1]),
                .down_data  (w_data[gi+1]),
                .down_ready (w_ready[gi+1]),
                .held       (w_held[gi])
            );
        end
    endgenerate

    // Ready is forced low while reset is held, independent of the stage state.
    assign upstream.ready   = ~rst & w_ready[0] & ~stall & ~flush;
    assign downstream.valid = w_valid[DEPTH] & ~stall;
    assign downstream.data  = w_data[DEPTH];

    always_comb begin
        w_count = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_count = w_count + COUNT_W'(w_held[i]);
        end
    end

    assign count = w_count;

endmodule

`default_nettype wire

// File: tb/tb_elastic_pipe_buffer.sv
// ============================================================================
// Module  : tb_elastic_pipe_buffer
// Brief   : Scoreboard bench for elastic_pipe_buffer at DEPTH=1 and DEPTH=2.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_elastic_pipe_buffer;

    localparam logic [15:0] c_flush2 = 16'hDEAD;

    logic       clk = 1'b0;
    logic       rst;
    logic       stall;
    logic       flush;
    logic [1:0] count1;
    logic [2:0] count2;

    elastic_pipe_buffer_if #(.WIDTH(16)) up1 ();
    elastic_pipe_buffer_if #(.WIDTH(16)) dn1 ();
    elastic_pipe_buffer_if #(.WIDTH(16)) up2 ();
    elastic_pipe_buffer_if #(.WIDTH(16)) dn2 ();

    elastic_pipe_buffer #(.WIDTH(16), .DEPTH(1)) u_dut1 (
        .clk        (clk),
        .rst        (rst),
        .upstream   (up1),
        .downstream (dn1),
        .stall      (stall),
        .flush      (flush),
        .count      (count1)
    );

    elastic_pipe_buffer #(.WIDTH(16), .DEPTH(2), .FLUSH_VALUE(c_flush2)) u_dut2 (
        .clk        (clk),
        .rst        (rst),
        .upstream   (up2),
        .downstream (dn2),
        .stall      (stall),
        .flush      (flush),
        .count      (count2)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [15:0] q1 [$];
    logic [15:0] q2 [$];
    logic        acc2;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Resolve this cycle's handshakes against the scoreboard, then cross one edge.
    task automatic tick();
        #1;
        if (dn1.valid && dn1.ready) begin
            if (q1.size() == 0) check_eq("d1_spurious", 32'd1, 32'd0);
            else check_eq("d1_data", 32'(dn1.data), 32'(q1.pop_front()));
        end
        if (up1.valid && up1.ready) q1.push_back(up1.data);
        if (dn2.valid && dn2.ready) begin
            if (q2.size() == 0) check_eq("d2_spurious", 32'd1, 32'd0);
            else check_eq("d2_data", 32'(dn2.data), 32'(q2.pop_front()));
        end
        acc2 = up2.valid & up2.ready;
        if (acc2) q2.push_back(up2.data);
        if (flush) begin
            q1.delete();
            q2.delete();
        end
        @(posedge clk);
        #1;
        check_eq("count1", 32'(count1), 32'(q1.size()));
        check_eq("count2", 32'(count2), 32'(q2.size()));
    endtask

    task automatic send2(input logic [15:0] v);
        up2.valid = 1'b1;
        up2.data  = v;
        tick();
        for (int n = 0; n < 20 && !acc2; n++) tick();
        check_eq("send2_acc", 32'(acc2), 32'd1);
    endtask

    task automatic drain2();
        up2.valid = 1'b0;
        dn2.ready = 1'b1;
        for (int n = 0; n < 20 && q2.size() != 0; n++) tick();
        check_eq("drain2_left", 32'(q2.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; stall = 1'b0; flush = 1'b0;
        up1.valid = 1'b0; up1.data = '0; dn1.ready = 1'b1;
        up2.valid = 1'b0; up2.data = '0; dn2.ready = 1'b1;
        #2;
        check_eq("rst_inready", 32'(up2.ready), 32'd0);
        check_eq("rst_outvalid1", 32'(dn1.valid), 32'd0);
        check_eq("rst_out1", 32'(dn1.data), 32'd0);
        check_eq("rst_out2", 32'(dn2.data), 32'(c_flush2));
        check_eq("rst_count2", 32'(count2), 32'd0);
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check_eq("rel_inready1", 32'(up1.ready), 32'd1);
        check_eq("rel_inready2", 32'(up2.ready), 32'd1);

        // DEPTH=1 streaming with no backpressure.
        for (int i = 1; i <= 8; i++) begin
            up1.valid = 1'b1;
            up1.data  = 16'(i);
            #1 check_eq("s1_inready", 32'(up1.ready), 32'd1);
            tick();
            if (i == 1) begin
                check_eq("s1_lat_valid", 32'(dn1.valid), 32'd1);
                check_eq("s1_lat_data", 32'(dn1.data), 32'h1);
            end
        end
        up1.valid = 1'b0;
        repeat (2) tick();

        // DEPTH=2 backpressure: exactly four beats absorbed.
        dn2.ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            up2.valid = 1'b1;
            up2.data  = 16'hA0 + 16'(i);
            #1 check_eq("bp_inready", 32'(up2.ready), 32'd1);
            tick();
        end
        up2.data = 16'hA4;
        #1;
        check_eq("bp_full_ready", 32'(up2.ready), 32'd0);
        check_eq("bp_full_count", 32'(count2), 32'd4);
        tick();
        dn2.ready = 1'b1;
        send2(16'hA4);
        send2(16'hA5);
        drain2();

        // DEPTH=2 streaming with a three-cycle stall.
        for (int i = 0; i < 10; i++) begin
            if (i == 4) begin
                stall     = 1'b1;
                up2.valid = 1'b1;
                up2.data  = 16'hD4;
                for (int k = 0; k < 3; k++) begin
                    #1;
                    check_eq("stall_outvalid", 32'(dn2.valid), 32'd0);
                    check_eq("stall_inready", 32'(up2.ready), 32'd0);
                    check_eq("stall_out", 32'(dn2.data), 32'(q2[0]));
                    tick();
                end
                stall = 1'b0;
            end
            send2(16'hD0 + 16'(i));
        end
        drain2();

        // Flush with three beats held; a beat offered during flush is refused.
        dn2.ready = 1'b0;
        send2(16'hB0); send2(16'hB1); send2(16'hB2);
        up2.valid = 1'b0;
        #1 check_eq("fl_pre_count", 32'(count2), 32'd3);
        flush = 1'b1; up2.valid = 1'b1; up2.data = 16'hBB;
        #1 check_eq("fl_inready", 32'(up2.ready), 32'd0);
        tick();
        flush = 1'b0; up2.valid = 1'b0;
        #1;
        check_eq("fl_outvalid", 32'(dn2.valid), 32'd0);
        check_eq("fl_out", 32'(dn2.data), 32'(c_flush2));
        dn2.ready = 1'b1;
        send2(16'hC0);
        up2.valid = 1'b0;
        #1 check_eq("fl_lat_early", 32'(dn2.valid), 32'd0);
        tick();
        check_eq("fl_lat_valid", 32'(dn2.valid), 32'd1);
        check_eq("fl_lat_data", 32'(dn2.data), 32'hC0);
        drain2();

        // Flush overrides stall.
        dn2.ready = 1'b0;
        send2(16'hE0); send2(16'hE1);
        up2.valid = 1'b0;
        stall = 1'b1; flush = 1'b1;
        tick();
        stall = 1'b0; flush = 1'b0;
        #1;
        check_eq("sf_count", 32'(count2), 32'd0);
        check_eq("sf_out", 32'(dn2.data), 32'(c_flush2));

        // Asynchronous reset between edges with two beats held.
        send2(16'hF0); send2(16'hF1);
        up2.valid = 1'b0;
        #3 rst = 1'b1;
        #1;
        check_eq("ar_outvalid", 32'(dn2.valid), 32'd0);
        check_eq("ar_out", 32'(dn2.data), 32'(c_flush2));
        check_eq("ar_count", 32'(count2), 32'd0);
        check_eq("ar_inready", 32'(up2.ready), 32'd0);
        q1.delete();
        q2.delete();
        #2 rst = 1'b0;
        dn2.ready = 1'b1;
        #1 check_eq("ar_rel_ready", 32'(up2.ready), 32'd1);
        send2(16'h51); send2(16'h52);
        drain2();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
